// File: rtl/fetch_pkg.sv
// Shared types and limits for the instruction fetch sequencer.
// States, wait-counter width and legal memory latency range.
package fetch_pkg;

  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 8;
  localparam int WAIT_W          = 4;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    T0_ADDR = 3'd2,
    T1_WAIT = 3'd3,
    T2_LOAD = 3'd4,
    HANDOFF = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_counter.sv
// Memory-wait down-counter for the fetch sequencer.
// Loaded on T1 entry, decremented on non-stalled wait cycles.
module fetch_wait_counter
  import fetch_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         in_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch control FSM: CLEAR, IDLE, T0, T1 wait, T2, HANDOFF.
// Optional completed-fetch counter enabled by FETCH_PERF_CNT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 in_reset_n,
  input  logic                 in_run,
  input  logic                 in_stall,
  input  logic                 in_ir_ready,
  output logic                 out_reg_clear,
  output logic                 out_pc_read,
  output logic                 out_mar_write,
  output logic                 out_inc_pc,
  output logic                 out_pc_write,
  output logic                 out_mem_read,
  output logic                 out_mdr_write,
  output logic                 out_mdr_select,
  output logic                 out_mdr_read,
  output logic                 out_ir_write,
  output logic                 out_ir_valid,
  output logic [2:0]           out_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] out_fetch_count
`endif
);

  if ((MEM_LATENCY < MEM_LATENCY_MIN) ||
      (MEM_LATENCY > MEM_LATENCY_MAX)) begin : g_lat_chk
    $error("fetch_sequencer: MEM_LATENCY out of range");
  end

  if (CNT_WIDTH < 1) begin : g_cnt_chk
    $error("fetch_sequencer: CNT_WIDTH must be >= 1");
  end

  localparam logic [WAIT_W-1:0] LoadVal = WAIT_W'(MEM_LATENCY - 1);

  fetch_state_e r_state;
  fetch_state_e w_next;
  logic         w_load;
  logic         w_dec;
  logic         w_zero;
  logic         w_accept;

  assign w_load   = (r_state == T0_ADDR) && !in_stall;
  assign w_dec    = (r_state == T1_WAIT) && !in_stall;
  assign w_accept = (r_state == HANDOFF) && in_ir_ready;

  fetch_wait_counter #(
    .W (WAIT_W)
  ) u_wait (
    .clk        (clk),
    .in_reset_n (in_reset_n),
    .i_load     (w_load),
    .i_load_val (LoadVal),
    .i_en       (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CLEAR:   w_next = IDLE;
      IDLE:    if (!in_stall && in_run) w_next = T0_ADDR;
      T0_ADDR: if (!in_stall) w_next = T1_WAIT;
      T1_WAIT: if (!in_stall && w_zero) w_next = T2_LOAD;
      T2_LOAD: if (!in_stall) w_next = HANDOFF;
      HANDOFF: if (in_ir_ready) w_next = in_run ? T0_ADDR : IDLE;
      default: w_next = CLEAR;
    endcase
  end

  // Strobes decode registered state; stall only masks the one-shot phases.
  always_comb begin
    out_reg_clear  = 1'b0;
    out_pc_read    = 1'b0;
    out_mar_write  = 1'b0;
    out_inc_pc     = 1'b0;
    out_pc_write   = 1'b0;
    out_mem_read   = 1'b0;
    out_mdr_write  = 1'b0;
    out_mdr_select = 1'b0;
    out_mdr_read   = 1'b0;
    out_ir_write   = 1'b0;
    out_ir_valid   = 1'b0;
    unique case (r_state)
      CLEAR: out_reg_clear = in_reset_n;
      T0_ADDR: begin
        out_pc_read   = !in_stall;
        out_mar_write = !in_stall;
        out_inc_pc    = !in_stall;
        out_pc_write  = !in_stall;
      end
      T1_WAIT: out_mem_read = 1'b1;
      T2_LOAD: begin
        out_mdr_write  = !in_stall;
        out_mdr_select = !in_stall;
        out_mdr_read   = !in_stall;
        out_ir_write   = !in_stall;
      end
      HANDOFF: out_ir_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_state = r_state;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_fetch_count;

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_fetch_count <= '0;
    end else if (w_accept && (r_fetch_count != '1)) begin
      r_fetch_count <= r_fetch_count + 1'b1;
    end
  end

  assign out_fetch_count = r_fetch_count;
`else
  logic w_unused;
  assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer (MEM_LATENCY=3, CNT_WIDTH=4).
// Stimulus pushes per-cycle expected outputs; a negedge monitor checks.
module tb_fetch_sequencer;

  localparam int ML = 3;
  localparam int CW = 4;

  // {reg_clear, pc_read, mar_write, inc_pc, pc_write, mem_read,
  //  mdr_write, mdr_select, mdr_read, ir_write, ir_valid, state}
  localparam logic [13:0] E_RST = 14'b0_0000_0_0000_0_000;
  localparam logic [13:0] E_CLR = 14'b1_0000_0_0000_0_000;
  localparam logic [13:0] E_IDL = 14'b0_0000_0_0000_0_001;
  localparam logic [13:0] E_T0  = 14'b0_1111_0_0000_0_010;
  localparam logic [13:0] E_T0S = 14'b0_0000_0_0000_0_010;
  localparam logic [13:0] E_T1  = 14'b0_0000_1_0000_0_011;
  localparam logic [13:0] E_T2  = 14'b0_0000_0_1111_0_100;
  localparam logic [13:0] E_T2S = 14'b0_0000_0_0000_0_100;
  localparam logic [13:0] E_HO  = 14'b0_0000_0_0000_1_101;

  typedef struct {
    logic [13:0] vec;
    int          cnt;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic stall = 1'b0;
  logic rdy = 1'b0;

  logic       reg_clear, pc_read, mar_write, inc_pc, pc_write;
  logic       mem_read, mdr_write, mdr_select, mdr_read, ir_write;
  logic       ir_valid;
  logic [2:0] state;
`ifdef FETCH_PERF_CNT_EN
  logic [CW-1:0] fcnt;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   e_cnt = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .MEM_LATENCY (ML),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk             (clk),
    .in_reset_n      (rst_n),
    .in_run          (run),
    .in_stall        (stall),
    .in_ir_ready     (rdy),
    .out_reg_clear   (reg_clear),
    .out_pc_read     (pc_read),
    .out_mar_write   (mar_write),
    .out_inc_pc      (inc_pc),
    .out_pc_write    (pc_write),
    .out_mem_read    (mem_read),
    .out_mdr_write   (mdr_write),
    .out_mdr_select  (mdr_select),
    .out_mdr_read    (mdr_read),
    .out_ir_write    (ir_write),
    .out_ir_valid    (ir_valid),
    .out_state       (state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .out_fetch_count (fcnt)
`endif
  );

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [13:0] act;
      e = sb.pop_front();
      act = {reg_clear, pc_read, mar_write, inc_pc, pc_write,
             mem_read, mdr_write, mdr_select, mdr_read, ir_write,
             ir_valid, state};
      n_cmp++;
      if (act !== e.vec) begin
        n_bad++;
        $display("FAIL %s: outputs got %b want %b", e.nm, act, e.vec);
      end
`ifdef FETCH_PERF_CNT_EN
      n_cmp++;
      if (fcnt !== CW'(e.cnt)) begin
        n_bad++;
        $display("FAIL %s_cnt: count got %0d want %0d", e.nm, fcnt, e.cnt);
      end
`endif
    end
  end

  task automatic step(input logic r, input logic ru, input logic st,
                      input logic rd, input logic [13:0] e,
                      input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = r;
    run   = ru;
    stall = st;
    rdy   = rd;
    x.vec = e;
    x.cnt = e_cnt;
    x.nm  = nm;
    sb.push_back(x);
  endtask

  task automatic bump();
    if (e_cnt < (1 << CW) - 1) e_cnt++;
  endtask

  task automatic fetch();
    step(1, 1, 0, 1, E_T0, "lp_t0");
    repeat (ML) step(1, 1, 0, 1, E_T1, "lp_t1");
    step(1, 1, 0, 1, E_T2, "lp_t2");
    step(1, 1, 0, 1, E_HO, "lp_ho");
    bump();
  endtask

  initial begin
    step(0, 0, 0, 0, E_RST, "rst0");
    step(0, 1, 0, 1, E_RST, "rst1");
    step(1, 1, 0, 1, E_CLR, "clear");
    step(1, 1, 0, 1, E_IDL, "idle");
    step(1, 1, 0, 1, E_T0,  "f1_t0");
    step(1, 1, 0, 1, E_T1,  "f1_t1a");
    step(1, 1, 0, 1, E_T1,  "f1_t1b");
    step(1, 1, 0, 1, E_T1,  "f1_t1c");
    step(1, 1, 0, 1, E_T2,  "f1_t2");
    step(1, 1, 0, 1, E_HO,  "f1_ho");
    bump();
    step(1, 1, 0, 0, E_T0,  "f2_t0");
    step(1, 1, 0, 0, E_T1,  "f2_t1a");
    step(1, 1, 1, 0, E_T1,  "f2_t1_st1");
    step(1, 1, 1, 0, E_T1,  "f2_t1_st2");
    step(1, 1, 0, 0, E_T1,  "f2_t1b");
    step(1, 1, 0, 0, E_T1,  "f2_t1c");
    step(1, 1, 1, 0, E_T2S, "f2_t2_st");
    step(1, 1, 0, 0, E_T2,  "f2_t2");
    step(1, 1, 0, 0, E_HO,  "f2_ho1");
    step(1, 1, 1, 0, E_HO,  "f2_ho2_st");
    step(1, 1, 0, 0, E_HO,  "f2_ho3");
    step(1, 1, 1, 0, E_HO,  "f2_ho4_st");
    step(1, 1, 0, 0, E_HO,  "f2_ho5");
    step(1, 1, 0, 0, E_HO,  "f2_ho6");
    step(1, 1, 1, 1, E_HO,  "f2_ho_acc_st");
    bump();
    step(1, 1, 0, 0, E_T0,  "f3_t0");
    step(1, 0, 0, 0, E_T1,  "f3_t1a_norun");
    step(1, 0, 0, 0, E_T1,  "f3_t1b");
    step(1, 0, 0, 0, E_T1,  "f3_t1c");
    step(1, 0, 0, 0, E_T2,  "f3_t2");
    step(1, 0, 0, 1, E_HO,  "f3_ho");
    bump();
    step(1, 0, 0, 1, E_IDL, "f3_idle");
    step(1, 1, 1, 1, E_IDL, "idle_st");
    step(1, 1, 0, 1, E_IDL, "idle_held");
    step(1, 1, 1, 1, E_T0S, "f4_t0_st");
    step(1, 1, 0, 1, E_T0,  "f4_t0");
    step(1, 1, 0, 1, E_T1,  "f4_t1a");
    step(1, 1, 0, 1, E_T1,  "f4_t1b");
    step(1, 1, 0, 1, E_T1,  "f4_t1c");
    e_cnt = 0;
    step(0, 1, 0, 1, E_RST, "rst_in_t2");
    step(0, 1, 0, 1, E_RST, "rst_hold");
    step(1, 0, 0, 1, E_CLR, "clear2");
    step(1, 0, 0, 1, E_IDL, "idle2");
    step(1, 1, 0, 1, E_IDL, "idle2_go");
    for (int i = 0; i < 18; i++) fetch();
    step(1, 0, 0, 1, E_T0,  "end_t0");
    repeat (ML) step(1, 0, 0, 1, E_T1, "end_t1");
    step(1, 0, 0, 1, E_T2,  "end_t2");
    step(1, 0, 0, 1, E_HO,  "end_ho");
    bump();
    step(1, 0, 0, 1, E_IDL, "end_idle");
    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: left %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, memory read latency in cycles (legal 1..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the fetch counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports are in the table below.
- clk  in  1  rising-edge clock
- in_reset_n  in  1  asynchronous active-low reset
- in_run  in  1  level; 1 = keep fetching
- in_stall  in  1  freeze sequencer this cycle
- in_ir_ready  in  1  consumer accepts the fetched instruction
- out_reg_clear  out  1  datapath register clear
- out_pc_read, out_mar_write, out_inc_pc, out_pc_write  out  1 each  T0 strobes
- out_mem_read  out  1  memory read enable
- out_mdr_write, out_mdr_select, out_mdr_read, out_ir_write  out  1 each  T2 strobes
- out_ir_valid  out  1  IR holds a fetched instruction
- out_state  out  3  current state code (debug)
- out_fetch_count  out  CNT_WIDTH  completed fetches (only with FETCH_PERF_CNT_EN)

Function
REQ-004 SHALL implement states CLEAR, IDLE, T0_ADDR, T1_WAIT, T2_LOAD, HANDOFF.
REQ-005 SHALL stay in CLEAR for exactly 1 cycle after reset release, with out_reg_clear=1, then go to IDLE.
REQ-006 SHALL go from IDLE to T0_ADDR when in_run=1; otherwise hold IDLE with all strobes 0.
REQ-007 T0_ADDR SHALL last 1 cycle, assert out_pc_read, out_mar_write, out_inc_pc and out_pc_write, then go to T1_WAIT.
REQ-008 T1_WAIT SHALL assert out_mem_read for exactly MEM_LATENCY non-stalled cycles, counted by a down-counter loaded on entry, then go to T2_LOAD.
REQ-009 T2_LOAD SHALL last 1 cycle, assert out_mdr_write, out_mdr_select, out_mdr_read and out_ir_write, then go to HANDOFF.
REQ-010 HANDOFF SHALL assert out_ir_valid and hold until in_ir_ready=1; on the accept cycle it SHALL go to T0_ADDR if in_run=1, else IDLE.
REQ-011 Fetch latency SHALL be 2+MEM_LATENCY cycles from entering T0_ADDR to entering HANDOFF; throughput with in_ir_ready held 1 SHALL be one fetch per 3+MEM_LATENCY cycles.
REQ-012 In_stall=1 SHALL hold state and wait counter; in T0_ADDR and T2_LOAD all strobes SHALL be 0 during stall; in T1_WAIT out_mem_read SHALL stay 1.
REQ-013 In_stall SHALL NOT suppress out_ir_valid; in HANDOFF, in_ir_ready overrides in_stall.
REQ-014 Deasserting in_run mid-fetch SHALL complete the current fetch through HANDOFF, then return to IDLE (no abort).
REQ-015 out_mdr_select SHALL be 0 in every state except T2_LOAD.
REQ-016 All outputs SHALL be registered-state decodes; no output SHALL combinationally depend on in_run or in_ir_ready.

Reset
REQ-017 in_reset_n=0 SHALL immediately (asynchronously) force state CLEAR, all strobes 0, out_ir_valid 0, and the wait counter and out_fetch_count 0.
REQ-018 Reset asserted mid-fetch SHALL discard the fetch; no partial strobe SHALL follow reset release other than the CLEAR cycle.

Configuration
REQ-019 With FETCH_PERF_CNT_EN defined, out_fetch_count SHALL increment on each HANDOFF accept, saturating at all-ones.
REQ-020 Without FETCH_PERF_CNT_EN, out_fetch_count SHALL be absent and no counter logic SHALL be generated.

Structure
REQ-021 Package fetch_pkg SHALL hold the state enum (3-bit codes CLEAR=0 .. HANDOFF=5) and the constants MEM_LATENCY_MIN=1 and MEM_LATENCY_MAX=8.
REQ-022 The wait down-counter SHALL be sub-module fetch_wait_counter (load, enable, zero flag); the rest is flat.
REQ-023 An elaboration check SHALL reject MEM_LATENCY outside 1..8.

Verification
REQ-024 Reset, then in_run=1, ready=1, MEM_LATENCY=1 -> CLEAR 1 cycle; T0 strobes at cycle 2, mem_read cycle 3, T2 strobes cycle 4, ir_valid cycle 5; repeats every 4 cycles.
REQ-025 MEM_LATENCY=3, in_stall=1 for 2 cycles in T1_WAIT -> out_mem_read high 5 cycles total; T2 strobes follow once.
REQ-026 in_ir_ready=0 for 6 cycles in HANDOFF -> out_ir_valid held 6+ cycles, no T0 strobe until the accept cycle.
REQ-027 in_run dropped during T1_WAIT -> fetch completes, ir_valid asserts, after accept state=IDLE and strobes 0.
REQ-028 in_reset_n pulsed low during T2_LOAD -> all outputs 0 same cycle; after release, one out_reg_clear cycle.
REQ-029 FETCH_PERF_CNT_EN, CNT_WIDTH=4, 20 fetches -> out_fetch_count saturates at 15.
